uart_transmit: RTL

//  8N1/8N2 UART transmitter, the TX counterpart to the design's UART receiver.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_transmit_if.sv | 21 ++
 rtl/uart_tx_fifo.sv | 72 +++++++
 rtl/uart_transmit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and baud
// timing helper used by both the TX and RX sides.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic int bit_period(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_transmit_if.sv
// Byte handshake between an on-chip producer and the UART
// transmitter: valid/byte forward, ready back.
interface uart_transmit_if;

  logic       data_valid_in;
  logic [7:0] data_byte_in;
  logic       ready_out;

  modport master (
    output data_valid_in,
    output data_byte_in,
    input  ready_out
  );

  modport slave (
    input  data_valid_in,
    input  data_byte_in,
    output ready_out
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO; head is visible on dout in the same
// cycle it becomes valid, so a pop and a use can share an edge.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    // count alone tells full from empty once pointers wrap
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmit.sv
// 8N1/8N2 UART transmitter: byte FIFO feeding a bit-timed
// serialiser, LSB first, idle-high line, back-to-back frames.
module uart_transmit
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int FIFO_DEPTH       = 4,
  parameter int STOP_BITS        = 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  uart_transmit_if.slave              bus,
  output logic                        tx_wire_out,
  output logic                        busy_out,
  output logic                        tx_done_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out
);

  localparam int BIT_PERIOD = bit_period(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam int DW         = $clog2(BIT_PERIOD * 2) + 1;

  localparam logic [DW-1:0] BIT_LAST  = DW'(BIT_PERIOD - 1);
  localparam logic [DW-1:0] STOP_LAST = DW'(STOP_BITS * BIT_PERIOD - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_transmit: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_transmit: FIFO_DEPTH must be a power of 2 >= 2");
  end

  tx_state_t     state_q, state_d;
  logic [DW-1:0] dclk_q, dclk_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    bit_nxt;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  assign bus.ready_out = !fifo_full;
  assign fifo_push     = bus.data_valid_in && bus.ready_out;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (bus.data_byte_in),
    .dout   (fifo_dout),
    .count  (fifo_count_out),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_nxt = bit_idx_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    dclk_d    = dclk_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        dclk_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (dclk_q == BIT_LAST) begin
          dclk_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          dclk_d = dclk_q + DW'(1);
        end
      end
      DATA: begin
        if (dclk_q == BIT_LAST) begin
          dclk_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_nxt;
            tx_d      = shift_q[bit_nxt];
          end
        end else begin
          dclk_d = dclk_q + DW'(1);
        end
      end
      STOP: begin
        if (dclk_q == STOP_LAST) begin
          dclk_d = '0;
          // chain straight into the next start bit when work is queued
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          dclk_d = dclk_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      dclk_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      dclk_q    <= dclk_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_wire_out = tx_q;
  assign tx_done_out = (state_q == STOP) && (dclk_q == STOP_LAST);
  assign busy_out    = (state_q != IDLE) || !fifo_empty;

endmodule
